// File: rtl/vc_switch_allocator.sv
// vc_switch_allocator: per-VC-plane switch controller.
// Each output port runs a two-state FSM (FREE / RESERVED) with its own
// round-robin pointer. A reservation (worm path) is held until the owning
// input pulses routeRelieve. Grants, input ownership and crossbar selects
// are all registered.
module vc_switch_allocator #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2,
  parameter int SEL_WIDTH     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            routeReserveRequestValid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [INPUTS-1:0]            routeRelieve,
  output logic [INPUTS-1:0]            routeReserveGrant,
  output logic [INPUTS-1:0]            inputReserved,
  output logic [OUTPUTS-1:0]           outputBusy,
  output logic [OUTPUTS*SEL_WIDTH-1:0] outputInputSelect
);

  typedef enum logic {
    FREE     = 1'b0,
    RESERVED = 1'b1
  } state_t;

  // Per-output one-hot contributions, merged below into per-input vectors.
  logic [INPUTS-1:0] take_arr    [OUTPUTS];
  logic [INPUTS-1:0] release_arr [OUTPUTS];

  logic [INPUTS-1:0] take_any;
  logic [INPUTS-1:0] release_any;
  logic [INPUTS-1:0] grant_reg;
  logic [INPUTS-1:0] reserved_reg;

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTS; gi++) begin : g_out
      state_t                 state_reg;
      logic [SEL_WIDTH-1:0]   owner_reg;
      logic [SEL_WIDTH-1:0]   rr_ptr_reg;
      logic [INPUTS-1:0]      eligible;
      logic [SEL_WIDTH-1:0]   winner;
      logic                   win_valid;
      logic                   owner_relieve;
      logic [SEL_WIDTH-1:0]   rr_next;
      logic [INPUTS-1:0]      take_local;
      logic [INPUTS-1:0]      release_local;

      // An input competes only when it targets this output, owns nothing
      // and is not releasing in the same cycle (relieve wins).
      always_comb begin
        eligible = '0;
        for (int i = 0; i < INPUTS; i++) begin
          eligible[i] = routeReserveRequestValid[i]
                      && (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH]
                          == REQUEST_WIDTH'(gi))
                      && !reserved_reg[i]
                      && !routeRelieve[i];
        end
      end

      // Round-robin pick: first eligible input scanning upward from the pointer.
      always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        winner    = '0;
        for (int k = 0; k < INPUTS; k++) begin
          idx = int'(rr_ptr_reg) + k;
          if (idx >= INPUTS) idx = idx - INPUTS;
          if (!win_valid && eligible[idx]) begin
            win_valid = 1'b1;
            winner    = SEL_WIDTH'(idx);
          end
        end
      end

      // Only the current owner's relieve can free this output.
      always_comb begin
        owner_relieve = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
          if (owner_reg == SEL_WIDTH'(i) && routeRelieve[i]) owner_relieve = 1'b1;
        end
      end

      assign rr_next = (winner == SEL_WIDTH'(INPUTS - 1)) ? '0 : winner + SEL_WIDTH'(1);

      // One-hot grant and release contributions of this output.
      always_comb begin
        take_local    = '0;
        release_local = '0;
        for (int i = 0; i < INPUTS; i++) begin
          take_local[i]    = (state_reg == FREE) && win_valid
                           && (winner == SEL_WIDTH'(i));
          release_local[i] = (state_reg == RESERVED) && owner_relieve
                           && (owner_reg == SEL_WIDTH'(i));
        end
      end

      assign take_arr[gi]    = take_local;
      assign release_arr[gi] = release_local;

      // Output FSM: a freed output is only arbitrated from the following cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg  <= FREE;
          owner_reg  <= '0;
          rr_ptr_reg <= '0;
        end else begin
          case (state_reg)
            FREE: begin
              if (win_valid) begin
                state_reg  <= RESERVED;
                owner_reg  <= winner;
                rr_ptr_reg <= rr_next;
              end
            end
            RESERVED: begin
              if (owner_relieve) state_reg <= FREE;
            end
            default: state_reg <= FREE;
          endcase
        end
      end

      assign outputBusy[gi] = (state_reg == RESERVED);
      assign outputInputSelect[gi*SEL_WIDTH +: SEL_WIDTH] = owner_reg;
    end
  endgenerate

  // Merge per-output contributions into per-input vectors.
  always_comb begin
    take_any    = '0;
    release_any = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      take_any    = take_any | take_arr[o];
      release_any = release_any | release_arr[o];
    end
  end

  // Grant pulse and input ownership; take and release never hit the same input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_reg    <= '0;
      reserved_reg <= '0;
    end else begin
      grant_reg    <= take_any;
      reserved_reg <= (reserved_reg & ~release_any) | take_any;
    end
  end

  assign routeReserveGrant = grant_reg;
  assign inputReserved     = reserved_reg;

endmodule

// File: tb/tb_vc_switch_allocator.sv
// Directed testbench for vc_switch_allocator: a 4x4 instance for the main
// scenarios and a 4x3 instance for out-of-range request indices.
module tb_vc_switch_allocator;

  logic       clk;
  logic       rst;

  logic [3:0] valid_a, rel_a, grant_a, resv_a, busy_a;
  logic [7:0] req_a, sel_a;

  logic [3:0] valid_b, rel_b, grant_b, resv_b;
  logic [7:0] req_b;
  logic [2:0] busy_b;
  logic [5:0] sel_b;

  int n_tests;
  int n_fail;

  vc_switch_allocator #(
    .INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(2), .SEL_WIDTH(2)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .routeReserveRequestValid(valid_a),
    .routeReserveRequest(req_a),
    .routeRelieve(rel_a),
    .routeReserveGrant(grant_a),
    .inputReserved(resv_a),
    .outputBusy(busy_a),
    .outputInputSelect(sel_a)
  );

  vc_switch_allocator #(
    .INPUTS(4), .OUTPUTS(3), .REQUEST_WIDTH(2), .SEL_WIDTH(2)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .routeReserveRequestValid(valid_b),
    .routeReserveRequest(req_b),
    .routeRelieve(rel_b),
    .routeReserveGrant(grant_b),
    .inputReserved(resv_b),
    .outputBusy(busy_b),
    .outputInputSelect(sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int exp_w [4] = '{0, 1, 3, 0};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    valid_a = '0; rel_a = '0; req_a = '0;
    valid_b = '0; rel_b = '0; req_b = '0;

    // Reset state
    repeat (2) tick();
    check("rst_grant", 32'(grant_a), 32'h0);
    check("rst_resv",  32'(resv_a),  32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);
    check("rst_sel",   32'(sel_a),   32'h0);
    rst = 1'b1;
    tick();

    // Single request: input 2 -> output 1
    valid_a[2] = 1'b1; req_a[5:4] = 2'd1;
    tick();
    check("single_grant", 32'(grant_a),    32'h4);
    check("single_busy",  32'(busy_a),     32'h2);
    check("single_sel1",  32'(sel_a[3:2]), 32'd2);
    check("single_resv",  32'(resv_a),     32'h4);
    valid_a[2] = 1'b0;
    tick();
    check("single_pulse_end", 32'(grant_a), 32'h0);
    check("single_busy_hold", 32'(busy_a),  32'h2);
    rel_a[2] = 1'b1;
    tick();
    rel_a = '0;
    check("single_rel_busy", 32'(busy_a), 32'h0);
    check("single_rel_resv", 32'(resv_a), 32'h0);

    // Round-robin contention on output 0 among inputs 0, 1, 3
    req_a = '0;
    valid_a = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("rr%0d_grant", n), 32'(grant_a), 32'(1 << exp_w[n]));
      check($sformatf("rr%0d_sel0", n),  32'(sel_a[1:0]), 32'(exp_w[n]));
      check($sformatf("rr%0d_busy", n),  32'(busy_a[0]), 32'h1);
      if (n == 3) valid_a = '0;
      tick();
      check($sformatf("rr%0d_noregrant", n), 32'(grant_a), 32'h0);
      rel_a[exp_w[n]] = 1'b1;
      tick();
      rel_a = '0;
      check($sformatf("rr%0d_freed", n), 32'(busy_a[0]), 32'h0);
    end
    check("rr_resv_end", 32'(resv_a), 32'h0);

    // Relieve with reuse gap on output 3
    valid_a[1] = 1'b1; req_a[3:2] = 2'd3;
    tick();
    check("gap_grant1", 32'(grant_a), 32'h2);
    check("gap_sel3a",  32'(sel_a[7:6]), 32'd1);
    valid_a[1] = 1'b0;
    valid_a[2] = 1'b1; req_a[5:4] = 2'd3;
    tick();
    check("gap_blocked", 32'(grant_a), 32'h0);
    tick();
    check("gap_blocked2", 32'(grant_a), 32'h0);
    check("gap_busy",     32'(busy_a[3]), 32'h1);
    rel_a[1] = 1'b1;
    tick();
    rel_a = '0;
    check("gap_freed",   32'(busy_a[3]), 32'h0);
    check("gap_no_same", 32'(grant_a),   32'h0);
    tick();
    check("gap_grant2", 32'(grant_a),    32'h4);
    check("gap_sel3b",  32'(sel_a[7:6]), 32'd2);
    check("gap_busy2",  32'(busy_a[3]),  32'h1);
    valid_a = '0;
    rel_a[2] = 1'b1;
    tick();
    rel_a = '0;
    check("gap_end_busy", 32'(busy_a), 32'h0);

    // Ignored events on the 3-output instance
    valid_b[1] = 1'b1; req_b[3:2] = 2'd0;
    tick();
    check("ign_setup_grant", 32'(grant_b), 32'h2);
    req_b[3:2] = 2'd2;
    rel_b[0]   = 1'b1;
    valid_b[2] = 1'b1; req_b[5:4] = 2'd3;
    repeat (2) begin
      tick();
      check("ign_grant", 32'(grant_b),    32'h0);
      check("ign_busy",  32'(busy_b),     32'h1);
      check("ign_resv",  32'(resv_b),     32'h2);
      check("ign_sel0",  32'(sel_b[1:0]), 32'd1);
    end
    valid_b = '0; rel_b = '0;
    rel_b[1] = 1'b1;
    tick();
    rel_b = '0;
    check("ign_end_busy", 32'(busy_b), 32'h0);

    // Parallel grants: 0->2, 1->3, 2->0, 3->1
    req_a   = {2'd1, 2'd0, 2'd3, 2'd2};
    valid_a = 4'b1111;
    tick();
    valid_a = '0;
    check("par_grant", 32'(grant_a), 32'hF);
    check("par_busy",  32'(busy_a),  32'hF);
    check("par_resv",  32'(resv_a),  32'hF);
    check("par_sel",   32'(sel_a),   32'h4E);

    // Asynchronous reset with three outputs busy (input 3 frees output 1)
    rel_a[3] = 1'b1;
    tick();
    rel_a = '0;
    check("ar_busy3", 32'(busy_a), 32'hD);
    #3;
    rst = 1'b0;
    #1;
    check("ar_busy",  32'(busy_a),  32'h0);
    check("ar_resv",  32'(resv_a),  32'h0);
    check("ar_grant", 32'(grant_a), 32'h0);
    check("ar_sel",   32'(sel_a),   32'h0);
    tick();
    rst = 1'b1;
    // Output 2 pointer was 1 before reset; inputs 0 and 3 compete -> 0 if pointer is 0
    req_a   = {2'd2, 2'd0, 2'd0, 2'd2};
    valid_a = 4'b1001;
    tick();
    valid_a = '0;
    check("ar_rr_grant", 32'(grant_a),    32'h1);
    check("ar_rr_sel2",  32'(sel_a[5:4]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
